// File: rtl/irq_pkg.sv
// -----------------------------------------------------------------------------
// irq_pkg
// Shared definitions for the interrupt-pending controller:
//   NUM_SRC     - number of request sources
//   ID_W        - width of a source index
//   irq_state_t - presentation FSM states
//   id_to_onehot - converts a source index into a one-hot clear vector
// -----------------------------------------------------------------------------
package irq_pkg;

  localparam int NUM_SRC = 3;
  localparam int ID_W    = 2;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } irq_state_t;

  // Index -> one-hot; an out-of-range index yields no bit so nothing is cleared.
  function automatic logic [NUM_SRC-1:0] id_to_onehot(input logic [ID_W-1:0] id);
    logic [NUM_SRC-1:0] oh;
    oh = 3'b000;
    case (id)
      2'd0:    oh = 3'b001;
      2'd1:    oh = 3'b010;
      2'd2:    oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage : irq_pkg

// File: rtl/irq_prio_pick.sv
// -----------------------------------------------------------------------------
// irq_prio_pick
// Combinational fixed-priority picker: the lowest set index of cand wins.
// Ports:
//   cand [2:0] in  - candidate sources (pending and unmasked)
//   any        out - at least one candidate is set
//   idx  [1:0] out - index of the winning candidate (0 when any = 0)
// -----------------------------------------------------------------------------
module irq_prio_pick
  import irq_pkg::*;
(
  input  logic [NUM_SRC-1:0] cand,
  output logic               any,
  output logic [ID_W-1:0]    idx
);

  // Priority encode, bit 0 highest.
  always_comb begin
    any = 1'b0;
    idx = 2'd0;
    if (cand[0]) begin
      any = 1'b1;
      idx = 2'd0;
    end else if (cand[1]) begin
      any = 1'b1;
      idx = 2'd1;
    end else if (cand[2]) begin
      any = 1'b1;
      idx = 2'd2;
    end else begin
      any = 1'b0;
      idx = 2'd0;
    end
  end

endmodule : irq_prio_pick

// File: rtl/irq_pending_ctrl.sv
// -----------------------------------------------------------------------------
// irq_pending_ctrl
// Captures request events from three sources into a pending register and
// presents the highest-priority unmasked source (bit 0 highest) on a
// registered valid/ack handshake. The acknowledged pending bit is cleared;
// an event arriving for an already pending source raises a sticky lost flag.
// Parameters:
//   EDGE - 1: rising-edge capture of req_in, 0: level capture
// Ports:
//   clk            in  - clock, all state on rising edge
//   rst            in  - asynchronous active-high reset
//   req_in   [2:0] in  - raw request lines
//   mask     [2:0] in  - 1 = source held pending but not presented
//   irq_ack        in  - acknowledge, honoured only while irq_valid = 1
//   lost_clr       in  - clears the lost flags
//   irq_valid      out - an interrupt ID is being presented
//   irq_id   [1:0] out - presented source index
//   pending  [2:0] out - pending register
//   lost     [2:0] out - sticky event-while-pending flags
// -----------------------------------------------------------------------------
module irq_pending_ctrl
  import irq_pkg::*;
#(
  parameter bit EDGE = 1'b1
)(
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] req_in,
  input  logic [NUM_SRC-1:0] mask,
  input  logic               irq_ack,
  input  logic               lost_clr,
  output logic               irq_valid,
  output logic [ID_W-1:0]    irq_id,
  output logic [NUM_SRC-1:0] pending,
  output logic [NUM_SRC-1:0] lost
);

  logic [NUM_SRC-1:0] req_q_r;
  logic [NUM_SRC-1:0] pending_r;
  logic [NUM_SRC-1:0] lost_r;
  irq_state_t         state_r;
  logic               valid_r;
  logic [ID_W-1:0]    id_r;

  logic [NUM_SRC-1:0] ev_s;
  logic               ack_hit_s;
  logic [NUM_SRC-1:0] clr_s;
  logic [NUM_SRC-1:0] pending_nxt_s;
  logic [NUM_SRC-1:0] lost_set_s;
  logic [NUM_SRC-1:0] lost_nxt_s;
  logic [NUM_SRC-1:0] cand_s;
  logic               pick_any_s;
  logic [ID_W-1:0]    pick_idx_s;
  irq_state_t         state_nxt_s;
  logic [ID_W-1:0]    id_nxt_s;

  // Event detection: rising edge against the delayed line, or the raw level.
  generate
    if (EDGE) begin : g_edge
      assign ev_s = req_in & ~req_q_r;
    end else begin : g_level
      assign ev_s = req_in;
    end
  endgenerate

  // An ack only counts while presenting; it clears exactly the presented bit.
  assign ack_hit_s = (state_r == PRESENT) & irq_ack;
  assign cand_s    = pending_r & ~mask;

  irq_prio_pick u_pick (
    .cand (cand_s),
    .any  (pick_any_s),
    .idx  (pick_idx_s)
  );

  // Pending/lost next-state: an event wins over its own clear, and a new
  // lost event wins over lost_clr in the same cycle.
  always_comb begin
    clr_s         = 3'b000;
    pending_nxt_s = pending_r;
    lost_set_s    = 3'b000;
    lost_nxt_s    = lost_r;
    if (ack_hit_s) begin
      clr_s = id_to_onehot(id_r);
    end else begin
      clr_s = 3'b000;
    end
    pending_nxt_s = (pending_r & ~clr_s) | ev_s;
    lost_set_s    = ev_s & pending_r & ~clr_s;
    if (lost_clr) begin
      lost_nxt_s = lost_set_s;
    end else begin
      lost_nxt_s = lost_r | lost_set_s;
    end
  end

  // Presentation FSM next-state: the ID is latched on entry to PRESENT and
  // frozen there, so neither new arrivals nor mask changes disturb it.
  always_comb begin
    state_nxt_s = state_r;
    id_nxt_s    = id_r;
    case (state_r)
      IDLE: begin
        if (pick_any_s) begin
          state_nxt_s = PRESENT;
          id_nxt_s    = pick_idx_s;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      PRESENT: begin
        if (irq_ack) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = PRESENT;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q_r   <= 3'b000;
      pending_r <= 3'b000;
      lost_r    <= 3'b000;
      state_r   <= IDLE;
      valid_r   <= 1'b0;
      id_r      <= 2'd0;
    end else begin
      req_q_r   <= req_in;
      pending_r <= pending_nxt_s;
      lost_r    <= lost_nxt_s;
      state_r   <= state_nxt_s;
      valid_r   <= (state_nxt_s == PRESENT);
      id_r      <= id_nxt_s;
    end
  end

  assign irq_valid = valid_r;
  assign irq_id    = id_r;
  assign pending   = pending_r;
  assign lost      = lost_r;

endmodule : irq_pending_ctrl

// File: tb/tb_irq_pending_ctrl.sv
// -----------------------------------------------------------------------------
// tb_irq_pending_ctrl
// Self-checking bench: directed scenarios followed by randomized traffic,
// all compared cycle by cycle against a behavioural model of the controller.
// -----------------------------------------------------------------------------
module tb_irq_pending_ctrl;

  logic       clk;
  logic       rst;
  logic [2:0] req_in;
  logic [2:0] mask;
  logic       irq_ack;
  logic       lost_clr;
  logic       irq_valid;
  logic [1:0] irq_id;
  logic [2:0] pending;
  logic [2:0] lost;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  bit [2:0] m_pend;
  bit [2:0] m_lost;
  bit [2:0] m_req_q;
  bit       m_valid;
  bit [1:0] m_id;

  irq_pending_ctrl #(.EDGE(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_in    (req_in),
    .mask      (mask),
    .irq_ack   (irq_ack),
    .lost_clr  (lost_clr),
    .irq_valid (irq_valid),
    .irq_id    (irq_id),
    .pending   (pending),
    .lost      (lost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pend  = 3'b000;
    m_lost  = 3'b000;
    m_req_q = 3'b000;
    m_valid = 1'b0;
    m_id    = 2'd0;
  endtask

  // One clock edge of the controller, evaluated from the behavioural rules.
  task automatic model_step();
    bit [2:0] ev;
    bit [2:0] clr;
    bit [2:0] np;
    bit [2:0] nl;
    int       fid;
    fid = -1;
    for (int i = 0; i < 3; i++) begin
      ev[i]  = req_in[i] && !m_req_q[i];
      clr[i] = m_valid && irq_ack && (int'(m_id) == i);
      np[i]  = ev[i] ? 1'b1 : (clr[i] ? 1'b0 : m_pend[i]);
      if (ev[i] && m_pend[i] && !clr[i]) nl[i] = 1'b1;
      else if (lost_clr)                 nl[i] = 1'b0;
      else                               nl[i] = m_lost[i];
    end
    if (!m_valid) begin
      for (int i = 2; i >= 0; i--)
        if (m_pend[i] && !mask[i]) fid = i;
      if (fid >= 0) begin
        m_valid = 1'b1;
        m_id    = 2'(fid);
      end
    end else if (irq_ack) begin
      m_valid = 1'b0;
    end
    m_pend  = np;
    m_lost  = nl;
    m_req_q = req_in;
  endtask

  task automatic check_all(input string ctx);
    check_eq({ctx, ".valid"},   32'(irq_valid), 32'(m_valid));
    check_eq({ctx, ".id"},      32'(irq_id),    32'(m_id));
    check_eq({ctx, ".pending"}, 32'(pending),   32'(m_pend));
    check_eq({ctx, ".lost"},    32'(lost),      32'(m_lost));
  endtask

  // Drive one cycle of inputs, step the model at the edge, compare after it.
  task automatic cyc(input logic [2:0] r, input logic [2:0] m, input logic a, input logic lc);
    req_in   = r;
    mask     = m;
    irq_ack  = a;
    lost_clr = lc;
    @(posedge clk);
    model_step();
    #1;
    check_all("cyc");
  endtask

  // Assert reset between edges and check the outputs fall without a clock.
  task automatic async_reset(input logic [2:0] hold_req);
    #2;
    rst     = 1'b1;
    req_in  = hold_req;
    irq_ack = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    req_in   = 3'b000;
    mask     = 3'b000;
    irq_ack  = 1'b0;
    lost_clr = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all("reset");
    rst = 1'b0;

    // Single pulse on source 2: pending at N+1, presented at N+2, ack clears.
    cyc(3'b000, 3'b000, 1'b0, 1'b0);
    cyc(3'b100, 3'b000, 1'b0, 1'b0);
    check_eq("t1.pend_n1", 32'(pending), 32'h4);
    check_eq("t1.valid_n1", 32'(irq_valid), 32'h0);
    cyc(3'b000, 3'b000, 1'b0, 1'b0);
    check_eq("t1.valid_n2", 32'(irq_valid), 32'h1);
    check_eq("t1.id_n2", 32'(irq_id), 32'h2);
    cyc(3'b000, 3'b000, 1'b1, 1'b0);
    check_eq("t1.pend_ack", 32'(pending), 32'h0);
    check_eq("t1.valid_ack", 32'(irq_valid), 32'h0);

    // All three rise together: IDs 0,1,2 with an idle gap between each.
    cyc(3'b111, 3'b000, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      cyc(3'b000, 3'b000, 1'b0, 1'b0);
      check_eq("t2.valid", 32'(irq_valid), 32'h1);
      check_eq("t2.id", 32'(irq_id), 32'(k));
      cyc(3'b000, 3'b000, 1'b1, 1'b0);
      check_eq("t2.gap", 32'(irq_valid), 32'h0);
    end

    // No preemption: source 0 arrives while 2 is presented.
    cyc(3'b100, 3'b000, 1'b0, 1'b0);
    cyc(3'b000, 3'b000, 1'b0, 1'b0);
    cyc(3'b001, 3'b000, 1'b0, 1'b0);
    cyc(3'b000, 3'b000, 1'b0, 1'b0);
    check_eq("t3.frozen", 32'(irq_id), 32'h2);
    cyc(3'b000, 3'b000, 1'b1, 1'b0);
    cyc(3'b000, 3'b000, 1'b0, 1'b0);
    check_eq("t3.valid0", 32'(irq_valid), 32'h1);
    check_eq("t3.id0", 32'(irq_id), 32'h0);
    cyc(3'b000, 3'b000, 1'b1, 1'b0);

    // Mask holds source 0 pending while 1 is served.
    cyc(3'b011, 3'b001, 1'b0, 1'b0);
    cyc(3'b000, 3'b001, 1'b0, 1'b0);
    check_eq("t4.id1", 32'(irq_id), 32'h1);
    cyc(3'b000, 3'b001, 1'b1, 1'b0);
    cyc(3'b000, 3'b001, 1'b0, 1'b0);
    check_eq("t4.masked_idle", 32'(irq_valid), 32'h0);
    check_eq("t4.pend_kept", 32'(pending), 32'h1);
    cyc(3'b000, 3'b000, 1'b0, 1'b0);
    check_eq("t4.id0", 32'(irq_id), 32'h0);
    check_eq("t4.valid0", 32'(irq_valid), 32'h1);
    cyc(3'b000, 3'b000, 1'b1, 1'b0);

    // Lost flag: sticky, cleared by lost_clr, not set by an edge on ack.
    cyc(3'b010, 3'b000, 1'b0, 1'b0);
    cyc(3'b000, 3'b000, 1'b0, 1'b0);
    cyc(3'b010, 3'b000, 1'b0, 1'b0);
    check_eq("t5.lost_set", 32'(lost), 32'h2);
    cyc(3'b000, 3'b000, 1'b0, 1'b0);
    check_eq("t5.lost_sticky", 32'(lost), 32'h2);
    cyc(3'b000, 3'b000, 1'b0, 1'b1);
    check_eq("t5.lost_clr", 32'(lost), 32'h0);
    cyc(3'b010, 3'b000, 1'b1, 1'b0);
    check_eq("t5.set_wins", 32'(pending), 32'h2);
    check_eq("t5.no_lost", 32'(lost), 32'h0);
    cyc(3'b000, 3'b000, 1'b0, 1'b0);
    cyc(3'b000, 3'b000, 1'b1, 1'b0);

    // Async reset mid-presentation, then stray acks while idle.
    cyc(3'b001, 3'b000, 1'b0, 1'b0);
    cyc(3'b000, 3'b000, 1'b0, 1'b0);
    check_eq("t6.pre_valid", 32'(irq_valid), 32'h1);
    async_reset(3'b000);
    check_eq("t6.valid_rst", 32'(irq_valid), 32'h0);
    for (int k = 0; k < 3; k++) cyc(3'b000, 3'b000, 1'b1, 1'b0);
    check_eq("t6.stray_pend", 32'(pending), 32'h0);

    // Line held high across reset release registers one event.
    async_reset(3'b100);
    cyc(3'b100, 3'b000, 1'b0, 1'b0);
    check_eq("t7.held", 32'(pending), 32'h4);
    cyc(3'b100, 3'b000, 1'b0, 1'b0);
    cyc(3'b000, 3'b000, 1'b1, 1'b0);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      logic [2:0] r;
      logic [2:0] m;
      r = 3'($urandom);
      m = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
      cyc(r, m, 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
      if ($urandom_range(0, 499) == 0) async_reset(3'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_irq_pending_ctrl
